// File: rtl/lsu.sv
// Load/store stage: registers one instruction from execute, runs req/gnt/rvalid to data memory, aligns and extends loads.
// Latency: non-memory ops 1 cycle; memory ops complete the cycle after i_mem_rvalid.
// Backpressure: o_pre_ready only while empty or draining to the WBU; the request is held until granted.
module lsu #(
    parameter int CPU_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    input  logic [CPU_WIDTH-1:0] i_exu_res,
    input  logic [CPU_WIDTH-1:0] i_exu_rs2,
    input  logic [2:0]           i_exu_lsfunc3,
    input  logic                 i_exu_lden,
    input  logic                 i_exu_sten,
    input  logic                 i_exu_fencei,
    input  logic [4:0]           i_exu_rdid,
    input  logic                 i_exu_rdwen,
    input  logic [11:0]          i_exu_csrdid,
    input  logic                 i_exu_csrdwen,
    input  logic [CPU_WIDTH-1:0] i_exu_csrd,
    input  logic [CPU_WIDTH-1:0] i_exu_pc,
    input  logic                 i_exu_ecall,
    input  logic                 i_exu_mret,
    input  logic                 i_exu_nop,
    input  logic [31:0]          s_exu_ins,
    output logic [CPU_WIDTH-1:0] o_lsu_res,
    output logic                 o_lsu_fencei,
    output logic [4:0]           o_lsu_rdid,
    output logic                 o_lsu_rdwen,
    output logic [11:0]          o_lsu_csrdid,
    output logic                 o_lsu_csrdwen,
    output logic [CPU_WIDTH-1:0] o_lsu_csrd,
    output logic [CPU_WIDTH-1:0] o_lsu_pc,
    output logic                 o_lsu_ecall,
    output logic                 o_lsu_mret,
    output logic                 o_lsu_nop,
    output logic [31:0]          s_lsu_ins,
    output logic                 o_mem_req,
    input  logic                 i_mem_gnt,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]           o_mem_wstrb,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                 state, state_nxt;
    logic                   valid_r;
    logic [CPU_WIDTH-1:0]   rs2_r;
    logic [2:0]             f3_r;
    logic                   lden_r;
    logic                   sten_r;

    logic                   pre_hs;
    logic                   post_hs;
    logic                   in_is_mem;
    logic                   in_req;
    logic [2:0]             off;
    logic [7:0]             strb_base;
    logic [CPU_WIDTH-1:0]   ld_shift;
    logic [CPU_WIDTH-1:0]   ld_data;

    assign in_is_mem    = i_exu_lden | i_exu_sten;
    assign o_post_valid = valid_r & ((state == S_IDLE) | (state == S_DONE));
    assign o_pre_ready  = ((o_post_valid & i_post_ready) | ~valid_r) & (state != S_DRAIN);
    // Flush wins over both handshakes: nothing is captured or retired in a flush cycle.
    assign pre_hs       = i_pre_valid & o_pre_ready & ~i_flush;
    assign post_hs      = o_post_valid & i_post_ready & ~i_flush;
    assign in_req       = (state == S_REQ);

    // Byte offset within the doubleword, forced down to the access's natural alignment.
    always_comb begin
        off       = o_lsu_res[2:0];
        strb_base = 8'h01;
        case (f3_r[1:0])
            2'b00: begin off = o_lsu_res[2:0];          strb_base = 8'h01; end
            2'b01: begin off = {o_lsu_res[2:1], 1'b0};  strb_base = 8'h03; end
            2'b10: begin off = {o_lsu_res[2], 2'b00};   strb_base = 8'h0F; end
            default: begin off = 3'd0;                  strb_base = 8'hFF; end
        endcase
    end

    assign ld_shift = i_mem_rdata >> {off, 3'b000};

    always_comb begin
        ld_data = '0;
        case (f3_r)
            3'b000: ld_data = {{(CPU_WIDTH-8){ld_shift[7]}},   ld_shift[7:0]};
            3'b001: ld_data = {{(CPU_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b010: ld_data = {{(CPU_WIDTH-32){ld_shift[31]}}, ld_shift[31:0]};
            3'b011: ld_data = ld_shift;
            3'b100: ld_data = {{(CPU_WIDTH-8){1'b0}},  ld_shift[7:0]};
            3'b101: ld_data = {{(CPU_WIDTH-16){1'b0}}, ld_shift[15:0]};
            3'b110: ld_data = {{(CPU_WIDTH-32){1'b0}}, ld_shift[31:0]};
            default: ld_data = '0;
        endcase
    end

    // Memory port is only driven while a request is pending, so it idles at zero.
    assign o_mem_req   = in_req;
    assign o_mem_wen   = in_req & sten_r;
    assign o_mem_addr  = in_req ? {o_lsu_res[CPU_WIDTH-1:3], 3'b000} : '0;
    assign o_mem_wdata = in_req ? (rs2_r << {off, 3'b000}) : '0;
    assign o_mem_wstrb = in_req ? (strb_base << off) : 8'h00;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!i_flush && pre_hs && in_is_mem) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_mem_gnt)    state_nxt = i_flush ? S_DRAIN : S_WAIT;
                else if (i_flush) state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (i_mem_rvalid) state_nxt = i_flush ? S_IDLE : S_DONE;
                else if (i_flush) state_nxt = S_DRAIN;
            end
            S_DONE: begin
                if (i_flush)      state_nxt = S_IDLE;
                else if (post_hs) state_nxt = (pre_hs && in_is_mem) ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (i_mem_rvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            valid_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (i_flush)      valid_r <= 1'b0;
            else if (pre_hs)  valid_r <= 1'b1;
            else if (post_hs) valid_r <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lsu_res     <= '0;
            rs2_r         <= '0;
            f3_r          <= 3'd0;
            lden_r        <= 1'b0;
            sten_r        <= 1'b0;
            o_lsu_fencei  <= 1'b0;
            o_lsu_rdid    <= 5'd0;
            o_lsu_rdwen   <= 1'b0;
            o_lsu_csrdid  <= 12'd0;
            o_lsu_csrdwen <= 1'b0;
            o_lsu_csrd    <= '0;
            o_lsu_pc      <= '0;
            o_lsu_ecall   <= 1'b0;
            o_lsu_mret    <= 1'b0;
            o_lsu_nop     <= 1'b0;
            s_lsu_ins     <= 32'd0;
        end else if (pre_hs) begin
            o_lsu_res     <= i_exu_res;
            rs2_r         <= i_exu_rs2;
            f3_r          <= i_exu_lsfunc3;
            lden_r        <= i_exu_lden;
            sten_r        <= i_exu_sten;
            o_lsu_fencei  <= i_exu_fencei;
            o_lsu_rdid    <= i_exu_rdid;
            o_lsu_rdwen   <= i_exu_rdwen;
            o_lsu_csrdid  <= i_exu_csrdid;
            o_lsu_csrdwen <= i_exu_csrdwen;
            o_lsu_csrd    <= i_exu_csrd;
            o_lsu_pc      <= i_exu_pc;
            o_lsu_ecall   <= i_exu_ecall;
            o_lsu_mret    <= i_exu_mret;
            o_lsu_nop     <= i_exu_nop;
            s_lsu_ins     <= s_exu_ins;
        end else if (state == S_WAIT && i_mem_rvalid && !i_flush && lden_r) begin
            o_lsu_res <= ld_data;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu with a byte-level reference model of alignment and extension.
module tb_lsu;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_pre_valid = 1'b0;
    logic        o_pre_ready, o_post_valid;
    logic        i_post_ready = 1'b1;
    logic [63:0] i_exu_res = '0, i_exu_rs2 = '0, i_exu_csrd = '0, i_exu_pc = '0;
    logic [2:0]  i_exu_lsfunc3 = '0;
    logic        i_exu_lden = 0, i_exu_sten = 0, i_exu_fencei = 0, i_exu_rdwen = 0;
    logic        i_exu_csrdwen = 0, i_exu_ecall = 0, i_exu_mret = 0, i_exu_nop = 0;
    logic [4:0]  i_exu_rdid = '0;
    logic [11:0] i_exu_csrdid = '0;
    logic [31:0] s_exu_ins = '0;
    logic [63:0] o_lsu_res, o_lsu_csrd, o_lsu_pc;
    logic        o_lsu_fencei, o_lsu_rdwen, o_lsu_csrdwen, o_lsu_ecall, o_lsu_mret, o_lsu_nop;
    logic [4:0]  o_lsu_rdid;
    logic [11:0] o_lsu_csrdid;
    logic [31:0] s_lsu_ins;
    logic        o_mem_req, o_mem_wen;
    logic        i_mem_gnt = 0, i_mem_rvalid = 0;
    logic [63:0] o_mem_addr, o_mem_wdata, i_mem_rdata = '0;
    logic [7:0]  o_mem_wstrb;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [4:0]  exp_rdid;
    logic [63:0] exp_pc;
    logic [31:0] exp_ins;

    always #5 i_clk = ~i_clk;

    lsu dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .i_exu_res(i_exu_res), .i_exu_rs2(i_exu_rs2), .i_exu_lsfunc3(i_exu_lsfunc3),
        .i_exu_lden(i_exu_lden), .i_exu_sten(i_exu_sten), .i_exu_fencei(i_exu_fencei),
        .i_exu_rdid(i_exu_rdid), .i_exu_rdwen(i_exu_rdwen), .i_exu_csrdid(i_exu_csrdid),
        .i_exu_csrdwen(i_exu_csrdwen), .i_exu_csrd(i_exu_csrd), .i_exu_pc(i_exu_pc),
        .i_exu_ecall(i_exu_ecall), .i_exu_mret(i_exu_mret), .i_exu_nop(i_exu_nop),
        .s_exu_ins(s_exu_ins),
        .o_lsu_res(o_lsu_res), .o_lsu_fencei(o_lsu_fencei), .o_lsu_rdid(o_lsu_rdid),
        .o_lsu_rdwen(o_lsu_rdwen), .o_lsu_csrdid(o_lsu_csrdid), .o_lsu_csrdwen(o_lsu_csrdwen),
        .o_lsu_csrd(o_lsu_csrd), .o_lsu_pc(o_lsu_pc), .o_lsu_ecall(o_lsu_ecall),
        .o_lsu_mret(o_lsu_mret), .o_lsu_nop(o_lsu_nop), .s_lsu_ins(s_lsu_ins),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    // Reference model: access is n = 2**funct3[1:0] bytes at the naturally aligned offset.
    function automatic int ref_off(input logic [63:0] addr, input logic [2:0] f3);
        int n = 1 << f3[1:0];
        return (int'(addr[2:0]) / n) * n;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [2:0] f3);
        int n = 1 << f3[1:0];
        int off = ref_off(addr, f3);
        logic [63:0] v = '0;
        if (f3 == 3'd7) return '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [2:0] f3);
        int n = 1 << f3[1:0];
        int off = ref_off(addr, f3);
        logic [7:0] s = '0;
        for (int b = 0; b < 8; b++) if (b >= off && b < off + n) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] rs2, input logic [63:0] addr,
                                              input logic [2:0] f3);
        int off = ref_off(addr, f3);
        logic [63:0] w = '0;
        for (int b = 0; b < 8; b++) if (b >= off) w[8*b +: 8] = rs2[8*(b-off) +: 8];
        return w;
    endfunction

    task automatic drive_ins(input logic [63:0] res, input logic [63:0] rs2, input logic [2:0] f3,
                             input logic ld, input logic st);
        i_exu_res = res; i_exu_rs2 = rs2; i_exu_lsfunc3 = f3;
        i_exu_lden = ld; i_exu_sten = st; i_exu_rdwen = ~st;
        i_exu_rdid = 5'($urandom); i_exu_pc = {$urandom, $urandom}; s_exu_ins = $urandom;
        exp_rdid = i_exu_rdid; exp_pc = i_exu_pc; exp_ins = s_exu_ins;
        i_pre_valid = 1'b1;
    endtask

    task automatic send(input logic [63:0] res, input logic [63:0] rs2, input logic [2:0] f3,
                        input logic ld, input logic st, output bit ok);
        ok = 1'b0;
        drive_ins(res, rs2, f3, ld, st);
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            if (o_pre_ready) begin ok = 1'b1; break; end
        end
        @(posedge i_clk); #1;
        i_pre_valid = 1'b0; i_exu_lden = 1'b0; i_exu_sten = 1'b0;
    endtask

    task automatic mem_serve(input int gd, input int rd, input logic [63:0] rdata,
                             output bit ok, output bit stable, output bit rdy_low,
                             output logic [63:0] addr, output logic [63:0] wdata,
                             output logic [7:0] strb, output logic wen);
        ok = 1'b0; stable = 1'b1; rdy_low = 1'b1;
        addr = '0; wdata = '0; strb = '0; wen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            if (o_mem_req) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        addr = o_mem_addr; wdata = o_mem_wdata; strb = o_mem_wstrb; wen = o_mem_wen;
        if (o_pre_ready) rdy_low = 1'b0;
        repeat (gd) begin
            @(posedge i_clk); @(negedge i_clk);
            if (!o_mem_req || o_mem_addr !== addr || o_mem_wstrb !== strb ||
                o_mem_wdata !== wdata || o_mem_wen !== wen) stable = 1'b0;
            if (o_pre_ready) rdy_low = 1'b0;
        end
        i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        repeat (rd) begin @(posedge i_clk); #1; end
        i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0; i_mem_rdata = {$urandom, $urandom};
    endtask

    task automatic test_reset;
        #2;
        total_cnt++; if (o_mem_req !== 1'b0 || o_post_valid !== 1'b0) $display("FAIL reset_ctrl: req=%b post_valid=%b want 0 0", o_mem_req, o_post_valid); else pass_cnt++;
        total_cnt++; if (o_lsu_res !== 64'd0 || o_lsu_pc !== 64'd0 || s_lsu_ins !== 32'd0 || o_mem_wstrb !== 8'd0 || o_mem_addr !== 64'd0) $display("FAIL reset_data: res=%h pc=%h ins=%h strb=%h addr=%h want 0", o_lsu_res, o_lsu_pc, s_lsu_ins, o_mem_wstrb, o_mem_addr); else pass_cnt++;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_passthrough;
        bit ok;
        send(64'h1234, 64'd0, 3'd0, 1'b0, 1'b0, ok);
        @(negedge i_clk);
        total_cnt++; if (!ok || o_post_valid !== 1'b1 || o_lsu_res !== 64'h1234) $display("FAIL pt_out: ok=%b valid=%b res=%h want 1 1 1234", ok, o_post_valid, o_lsu_res); else pass_cnt++;
        total_cnt++; if (o_lsu_rdwen !== 1'b1 || o_lsu_rdid !== exp_rdid || o_lsu_pc !== exp_pc || s_lsu_ins !== exp_ins) $display("FAIL pt_side: rdwen=%b rdid=%0d pc=%h ins=%h want 1 %0d %h %h", o_lsu_rdwen, o_lsu_rdid, o_lsu_pc, s_lsu_ins, exp_rdid, exp_pc, exp_ins); else pass_cnt++;
        total_cnt++; if (o_mem_req !== 1'b0) $display("FAIL pt_noreq: req=%b want 0", o_mem_req); else pass_cnt++;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        total_cnt++; if (o_post_valid !== 1'b0 || o_mem_req !== 1'b0) $display("FAIL pt_retire: valid=%b req=%b want 0 0", o_post_valid, o_mem_req); else pass_cnt++;
        @(posedge i_clk); #1;
    endtask

    task automatic run_load(input string nm, input logic [63:0] addr, input logic [2:0] f3,
                            input logic [63:0] rdata, input int gd, input int rd);
        bit ok, sok, st, rl;
        logic [63:0] a, w; logic [7:0] s; logic we;
        send(addr, 64'd0, f3, 1'b1, 1'b0, ok);
        mem_serve(gd, rd, rdata, sok, st, rl, a, w, s, we);
        @(negedge i_clk);
        total_cnt++; if (!ok || !sok || a !== {addr[63:3], 3'b000} || we !== 1'b0) $display("FAIL %s_req: ok=%b%b addr=%h wen=%b want %h 0", nm, ok, sok, a, we, {addr[63:3], 3'b000}); else pass_cnt++;
        total_cnt++; if (o_post_valid !== 1'b1 || o_lsu_res !== ref_load(rdata, addr, f3)) $display("FAIL %s_res: valid=%b res=%h want 1 %h", nm, o_post_valid, o_lsu_res, ref_load(rdata, addr, f3)); else pass_cnt++;
        @(posedge i_clk); #1;
    endtask

    task automatic run_store(input string nm, input logic [63:0] addr, input logic [2:0] f3,
                             input logic [63:0] rs2, input int gd, input int rd);
        bit ok, sok, st, rl;
        logic [63:0] a, w; logic [7:0] s; logic we;
        send(addr, rs2, f3, 1'b0, 1'b1, ok);
        mem_serve(gd, rd, {$urandom, $urandom}, sok, st, rl, a, w, s, we);
        @(negedge i_clk);
        total_cnt++; if (!ok || !sok || a !== {addr[63:3], 3'b000} || we !== 1'b1) $display("FAIL %s_req: ok=%b%b addr=%h wen=%b want %h 1", nm, ok, sok, a, we, {addr[63:3], 3'b000}); else pass_cnt++;
        total_cnt++; if (s !== ref_strb(addr, f3) || w !== ref_wdata(rs2, addr, f3)) $display("FAIL %s_lane: strb=%h wdata=%h want %h %h", nm, s, w, ref_strb(addr, f3), ref_wdata(rs2, addr, f3)); else pass_cnt++;
        total_cnt++; if (o_post_valid !== 1'b1 || o_lsu_res !== addr || o_lsu_rdwen !== 1'b0) $display("FAIL %s_res: valid=%b res=%h rdwen=%b want 1 %h 0", nm, o_post_valid, o_lsu_res, o_lsu_rdwen, addr); else pass_cnt++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_load_directed;
        run_load("lb", 64'h8000_0003, 3'b000, 64'h0000_0000_8000_0000, 0, 0);
        total_cnt++; if (o_lsu_res !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_const: res=%h want ffffffffffffff80", o_lsu_res); else pass_cnt++;
        run_load("lbu", 64'h8000_0003, 3'b100, 64'h0000_0000_8000_0000, 1, 2);
        total_cnt++; if (o_lsu_res !== 64'h80) $display("FAIL lbu_const: res=%h want 80", o_lsu_res); else pass_cnt++;
        run_load("f3_111", 64'h8000_0010, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    endtask

    task automatic test_store_directed;
        run_store("sh", 64'h1006, 3'b001, 64'hABCD, 0, 0);
        total_cnt++; if (ref_strb(64'h1006, 3'b001) !== 8'hC0 || ref_wdata(64'hABCD, 64'h1006, 3'b001) !== 64'hABCD_0000_0000_0000) $display("FAIL sh_model: strb=%h wdata=%h want c0 abcd000000000000", ref_strb(64'h1006, 3'b001), ref_wdata(64'hABCD, 64'h1006, 3'b001)); else pass_cnt++;
    endtask

    task automatic test_random_mem;
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                run_load("rnd_ld", a, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                run_store("rnd_st", a, 3'($urandom_range(0, 3)), {$urandom, $urandom},
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_grant_stall;
        bit ok, sok, st, rl;
        logic [63:0] a, w; logic [7:0] s; logic we;
        int extra = 0;
        send(64'h2000_0104, 64'h1122_3344_5566_7788, 3'b010, 1'b0, 1'b1, ok);
        mem_serve(5, 1, 64'd0, sok, st, rl, a, w, s, we);
        total_cnt++; if (!ok || !sok || !st) $display("FAIL stall_stable: ok=%b%b stable=%b want 1 1 1", ok, sok, st); else pass_cnt++;
        total_cnt++; if (!rl) $display("FAIL stall_prerdy: pre_ready seen high=%b want 0", !rl); else pass_cnt++;
        total_cnt++; if (s !== 8'hF0 || w !== 64'h5566_7788_0000_0000) $display("FAIL stall_lane: strb=%h wdata=%h want f0 5566778800000000", s, w); else pass_cnt++;
        repeat (4) begin
            @(negedge i_clk); if (o_mem_req) extra++;
            @(posedge i_clk); #1;
        end
        total_cnt++; if (extra != 0) $display("FAIL stall_single: extra req cycles=%0d want 0", extra); else pass_cnt++;
    endtask

    task automatic test_flush;
        bit ok, bad_valid = 0, bad_rdy = 0, seen = 0;
        // Flush while the request is still ungranted.
        send(64'h3000, 64'd0, 3'b011, 1'b1, 1'b0, ok);
        i_flush = 1'b1; @(posedge i_clk); #1; i_flush = 1'b0;
        @(negedge i_clk);
        total_cnt++; if (!ok || o_mem_req !== 1'b0 || o_pre_ready !== 1'b1 || o_post_valid !== 1'b0) $display("FAIL flush_req: req=%b rdy=%b valid=%b want 0 1 0", o_mem_req, o_pre_ready, o_post_valid); else pass_cnt++;
        @(posedge i_clk); #1;
        // Flush after grant: response must be swallowed.
        send(64'h3008, 64'd0, 3'b011, 1'b1, 1'b0, ok);
        for (int c = 0; c < 50 && !seen; c++) begin @(negedge i_clk); seen = o_mem_req; end
        i_mem_gnt = 1'b1; @(posedge i_clk); #1; i_mem_gnt = 1'b0;
        i_flush = 1'b1; @(posedge i_clk); #1; i_flush = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_post_valid) bad_valid = 1; if (o_pre_ready) bad_rdy = 1;
            @(posedge i_clk); #1;
        end
        i_mem_rvalid = 1'b1; i_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge i_clk);
        if (o_post_valid) bad_valid = 1; if (o_pre_ready) bad_rdy = 1;
        @(posedge i_clk); #1; i_mem_rvalid = 1'b0;
        total_cnt++; if (!ok || !seen || bad_valid || bad_rdy) $display("FAIL flush_drain: ok=%b%b valid_seen=%b rdy_seen=%b want 1 1 0 0", ok, seen, bad_valid, bad_rdy); else pass_cnt++;
        @(negedge i_clk);
        total_cnt++; if (o_pre_ready !== 1'b1 || o_post_valid !== 1'b0) $display("FAIL flush_after: rdy=%b valid=%b want 1 0", o_pre_ready, o_post_valid); else pass_cnt++;
        @(posedge i_clk); #1;
        run_load("post_flush", 64'h4002, 3'b001, 64'h0000_0000_7FFF_0000, 0, 1);
    endtask

    task automatic test_done_hold;
        bit ok, sok, st, rl, drop = 0;
        logic [63:0] a, w; logic [7:0] s; logic we;
        i_post_ready = 1'b0;
        send(64'h5005, 64'd0, 3'b000, 1'b1, 1'b0, ok);
        mem_serve(0, 0, 64'h0000_7F00_0000_0000, sok, st, rl, a, w, s, we);
        repeat (3) begin
            @(negedge i_clk); if (o_post_valid !== 1'b1 || o_lsu_res !== 64'h7F) drop = 1;
            @(posedge i_clk); #1;
        end
        total_cnt++; if (!ok || !sok || drop) $display("FAIL done_hold: ok=%b%b dropped=%b want 1 1 0", ok, sok, drop); else pass_cnt++;
        drive_ins(64'h9999, 64'd0, 3'd0, 1'b0, 1'b0);
        i_post_ready = 1'b1;
        @(negedge i_clk);
        total_cnt++; if (o_pre_ready !== 1'b1) $display("FAIL done_same_cycle: pre_ready=%b want 1", o_pre_ready); else pass_cnt++;
        @(posedge i_clk); #1; i_pre_valid = 1'b0;
        @(negedge i_clk);
        total_cnt++; if (o_post_valid !== 1'b1 || o_lsu_res !== 64'h9999 || o_mem_req !== 1'b0) $display("FAIL done_next: valid=%b res=%h req=%b want 1 9999 0", o_post_valid, o_lsu_res, o_mem_req); else pass_cnt++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] prev = '0;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] r = {$urandom, $urandom};
            drive_ins(r, 64'd0, 3'd0, 1'b0, 1'b0);
            @(negedge i_clk);
            if (o_pre_ready !== 1'b1) bad++;
            if (i > 0 && (o_post_valid !== 1'b1 || o_lsu_res !== prev)) bad++;
            prev = r;
            @(posedge i_clk); #1;
        end
        i_pre_valid = 1'b0;
        @(negedge i_clk);
        if (o_post_valid !== 1'b1 || o_lsu_res !== prev) bad++;
        total_cnt++; if (bad != 0) $display("FAIL b2b: bad cycles=%0d want 0", bad); else pass_cnt++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_mid_wait;
        bit ok, seen = 0;
        send(64'h6000_0007, 64'd0, 3'b000, 1'b1, 1'b0, ok);
        for (int c = 0; c < 50 && !seen; c++) begin @(negedge i_clk); seen = o_mem_req; end
        i_mem_gnt = 1'b1; @(posedge i_clk); #1; i_mem_gnt = 1'b0;
        #2; i_rst_n = 1'b0; #1;
        total_cnt++; if (!ok || !seen || o_mem_req !== 1'b0 || o_post_valid !== 1'b0 || o_lsu_res !== 64'd0 || o_lsu_pc !== 64'd0 || o_lsu_rdid !== 5'd0 || s_lsu_ins !== 32'd0) $display("FAIL rst_wait: req=%b valid=%b res=%h pc=%h rdid=%0d ins=%h want all 0", o_mem_req, o_post_valid, o_lsu_res, o_lsu_pc, o_lsu_rdid, s_lsu_ins); else pass_cnt++;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        total_cnt++; if (o_pre_ready !== 1'b1 || o_mem_req !== 1'b0) $display("FAIL rst_idle: rdy=%b req=%b want 1 0", o_pre_ready, o_mem_req); else pass_cnt++;
        @(posedge i_clk); #1;
        test_passthrough();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_directed();
        test_store_directed();
        test_grant_stall();
        test_random_mem();
        test_flush();
        test_done_hold();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store pipeline stage between the execute stage and the write-back stage. Registers one instruction per handshake from execute, issues loads and stores to the data-memory port with a request/grant/response protocol, and aligns and extends load data. Forwards all write-back fields to the WBU. Non-memory instructions pass through with one cycle of latency.

## Interface
- CPU_WIDTH, 64, datapath and address width (fixed at 64 for RV64).
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  kill the held instruction and any ungranted request.
- i_pre_valid / o_pre_ready  in/out  1  handshake with the execute stage.
- o_post_valid / i_post_ready  out/in  1  handshake with the WBU.
- i_exu_res  in  64  ALU result; memory address for loads and stores.
- i_exu_rs2  in  64  store data.
- i_exu_lsfunc3  in  3  access size and sign (RISC-V funct3).
- i_exu_lden, i_exu_sten, i_exu_fencei  in  1 each  load, store, fence.i.
- i_exu_rdid (5), i_exu_rdwen (1), i_exu_csrdid (12), i_exu_csrdwen (1), i_exu_csrd (64), i_exu_pc (64), i_exu_ecall, i_exu_mret, i_exu_nop (1 each), s_exu_ins (32)  in  write-back sidebands.
- o_lsu_* (same set and widths, minus lden/sten/rs2/lsfunc3), s_lsu_ins  out  registered sidebands to the WBU.
- o_lsu_res  out  64  load data when lden, otherwise i_exu_res.
- o_mem_req  out  1  request valid. Held until granted.
- i_mem_gnt  in  1  request accepted this cycle.
- o_mem_wen  out  1  1 = store.
- o_mem_addr  out  64  {res[63:3], 3'b000}.
- o_mem_wdata  out  64  store data shifted to its byte lane.
- o_mem_wstrb  out  8  byte enables.
- i_mem_rvalid  in  1  response for the oldest granted request. Comes for stores too.
- i_mem_rdata  in  64  read doubleword.

## Operation
- Stage register: o_pre_ready = (o_post_valid & i_post_ready) | !valid_r. On pre handshake, all inputs are captured.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: valid_r holds a non-memory instruction, so o_post_valid = valid_r. If a captured instruction has lden|sten, the FSM goes to REQ next cycle.
- REQ: o_mem_req = 1, and addr, wen, wdata and wstrb are held stable. On i_mem_gnt the FSM goes to WAIT.
- WAIT: on i_mem_rvalid, the aligned load data is captured and the FSM goes to DONE.
- DONE: o_post_valid = 1 until i_post_ready. Then the FSM goes to IDLE, or to REQ if the new captured instruction is a memory op.
- Size and offset: the byte offset is addr[2:0], with its low bits masked to size alignment (h: [0] = 0, w: [1:0] = 0, d: 0).
- wstrb per size: 8'h01 / 8'h03 / 8'h0F / 8'hFF, each << offset. wdata = rs2 << (8*offset).
- Loads: data = rdata >> (8*offset). Then extend by funct3: 000 lb, 001 lh, 010 lw, 011 ld (sign-extend); 100 lbu, 101 lhu, 110 lwu (zero-extend). funct3 111 returns 0.
- Stores and non-loads: o_lsu_res = registered i_exu_res. o_lsu_rdwen passes through unchanged.
- Flush in IDLE, DONE, or REQ without a same-cycle grant: valid_r is cleared, o_mem_req drops next cycle, and the FSM returns to IDLE.
- Flush in WAIT, or in REQ with a same-cycle grant: the FSM goes to DRAIN. It waits for i_mem_rvalid, discards it, then returns to IDLE.
  - o_pre_ready = 0 while in DRAIN.
  - A flushed store that was already granted is committed by memory; that is accepted.
- A nop captured (i_exu_nop = 1) with lden/sten = 0 never touches memory.

## Timing
- Reset: FSM = IDLE; valid_r = 0; every o_* output and s_lsu_ins = 0.
- Non-memory latency: o_post_valid is high in the cycle after acceptance. Back-to-back throughput is 1 per cycle.
- Memory latency: accepted at cycle N; o_mem_req at N+1; grant at G ≥ N+1; rvalid at R ≥ G+1; o_post_valid at R+1.
- Requests are never withdrawn without flush. Only one request is outstanding at a time.
- Simultaneous i_post_ready and i_pre_valid in DONE: the next instruction is accepted in the same cycle.
- Flush has priority over every handshake in the same cycle.

## Test plan
- Pass-through: add with res = 0x1234, rdwen = 1, post_ready held high → o_post_valid one cycle later with o_lsu_res = 0x1234; no o_mem_req.
- lb: addr 0x8000_0003, rdata = 0x0000_0000_8000_0000, funct3 = 000 → o_mem_addr 0x8000_0000, o_lsu_res = 0xFFFF_FFFF_FFFF_FF80. Same stimulus with lbu → 0x80.
- sh: addr 0x1006, rs2 = 0xABCD → wstrb = 0xC0, wdata = 0xABCD_0000_0000_0000, wen = 1. o_post_valid the cycle after rvalid.
- Grant stall: gnt withheld 5 cycles → req, addr and wstrb stable throughout; o_pre_ready = 0; a single transaction results.
- Flush in WAIT: rvalid arrives 3 cycles later → no o_post_valid; o_pre_ready = 0 until the cycle after rvalid; the next load completes normally.
- Reset asserted mid-WAIT → all outputs 0 immediately; FSM is IDLE after release.
